// File: rtl/pc_sequencer_pkg.sv
// Shared CPU package for the program-counter sequencer.
// Contents:
//   state_t            - sequencer FSM states (FETCH, DECODE, EXEC)
//   PC_STEP            - default byte distance between sequential instructions
//   OFFSET_MSB/LSB     - location of the 8-bit branch offset inside instr
//   sext_offset_bytes  - sign-extends an 8-bit word offset to a 32-bit byte offset
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2
  } state_t;

  localparam int PC_STEP    = 4;
  localparam int OFFSET_MSB = 23;
  localparam int OFFSET_LSB = 16;
  localparam int OFFSET_W   = OFFSET_MSB - OFFSET_LSB + 1;

  // Offsets count instructions (words), so the byte offset is the sign-extended
  // value shifted left by two.
  function automatic logic [31:0] sext_offset_bytes(input logic [OFFSET_W-1:0] off);
    return {{(32 - OFFSET_W - 2){off[OFFSET_W-1]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_branch_target.sv
// branch_target: purely combinational next-PC calculation.
// Ports:
//   pc       in  32  current program counter
//   offset8  in   8  signed word offset taken from the instruction
//   take     in   1  1 = apply the offset (jump or taken branch)
//   next_pc  out 32  pc + STEP (+ sext(offset8)<<2 when take), modulo 2^32
module branch_target
  import pc_sequencer_pkg::*;
#(
  parameter int STEP = PC_STEP
) (
  input  logic [31:0] pc,
  input  logic [7:0]  offset8,
  input  logic        take,
  output logic [31:0] next_pc
);

  logic [31:0] seq_pc;
  logic [31:0] offset_bytes;

  assign seq_pc       = pc + 32'(STEP);
  assign offset_bytes = take ? sext_offset_bytes(offset8) : 32'd0;
  // 32-bit adders drop the carry, which gives the required wrap-around.
  assign next_pc      = seq_pc + offset_bytes;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: three-state FETCH/DECODE/EXEC instruction sequencer.
// Ports:
//   CLK         in   1  clock, all state changes on the rising edge
//   RESET       in   1  synchronous active-high reset
//   imem_busy   in   1  instruction memory busy; rdata valid when low during a fetch
//   imem_rdata  in  32  instruction word from memory
//   jump        in   1  unconditional jump flag (looked at only in EXEC)
//   branch      in   1  beq flag (looked at only in EXEC)
//   zero        in   1  ALU zero flag (looked at only in EXEC)
//   pc          out 32  address of the instruction being fetched/executed
//   imem_read   out  1  fetch request, high for every FETCH cycle
//   instr       out 32  instruction register, loaded on a completed fetch
//   exec_en     out  1  one-cycle commit pulse in EXEC
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = pc_sequencer_pkg::PC_STEP
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        imem_busy,
  input  logic [31:0] imem_rdata,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] pc,
  output logic        imem_read,
  output logic [31:0] instr,
  output logic        exec_en
);

  import pc_sequencer_pkg::*;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic [31:0] pc_next;
  logic        take;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:   if (!imem_busy) state_next = DECODE;
      DECODE:  state_next = EXEC;
      EXEC:    state_next = FETCH;
      // The unused encoding recovers to FETCH so the FSM cannot lock up.
      default: state_next = FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from the registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_read = 1'b0;
    exec_en   = 1'b0;
    case (state_reg)
      FETCH:   imem_read = 1'b1;
      EXEC:    exec_en   = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Instruction register: only a completed fetch changes it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      instr_reg <= 32'd0;
    end else if (state_reg == FETCH && !imem_busy) begin
      instr_reg <= imem_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------------
  // Control flags are qualified by EXEC so stray values in other states are
  // ignored; jump dominates, so jump with branch is taken regardless of zero.
  assign take = (state_reg == EXEC) && (jump || (branch && zero));

  branch_target #(
    .STEP (PC_STEP)
  ) u_branch_target (
    .pc      (pc_reg),
    .offset8 (instr_reg[OFFSET_MSB:OFFSET_LSB]),
    .take    (take),
    .next_pc (pc_next)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_reg <= RESET_PC;
    end else if (state_reg == EXEC) begin
      pc_reg <= pc_next;
    end
  end

  assign pc    = pc_reg;
  assign instr = instr_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer. Inputs are driven and outputs sampled on
// the falling clock edge; all expected PCs are hand-computed constants.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        imem_busy = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] pc;
  logic        imem_read;
  logic [31:0] instr;
  logic        exec_en;

  int n_cmp = 0;
  int n_bad = 0;

  pc_sequencer #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .imem_busy  (imem_busy),
    .imem_rdata (imem_rdata),
    .jump       (jump),
    .branch     (branch),
    .zero       (zero),
    .pc         (pc),
    .imem_read  (imem_read),
    .instr      (instr),
    .exec_en    (exec_en)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Drives one instruction from the start of FETCH to the start of the next
  // FETCH and reports what was observed. Control flags carry inverted junk
  // outside EXEC so sampling them anywhere else would disturb the PC.
  task automatic run_instr(input logic [31:0] word, input int busy_n,
                           input logic j, input logic b, input logic z,
                           output int fetch_cyc, output logic held,
                           output logic [31:0] instr_dec, output logic dec_ok,
                           output logic ex_ok, output logic [31:0] pc_after);
    logic [31:0] pc0;
    logic [31:0] instr0;
    pc0 = pc;
    instr0 = instr;
    fetch_cyc = 0;
    held = 1'b1;
    jump = ~j; branch = ~b; zero = ~z;
    for (int i = 0; i < busy_n; i++) begin
      if (imem_read === 1'b1 && exec_en === 1'b0 && pc === pc0) fetch_cyc++;
      if (instr !== instr0) held = 1'b0;
      imem_busy = 1'b1;
      imem_rdata = $urandom;
      @(negedge CLK);
    end
    if (instr !== instr0) held = 1'b0;
    if (imem_read === 1'b1 && exec_en === 1'b0 && pc === pc0) fetch_cyc++;
    imem_busy = 1'b0;
    imem_rdata = word;
    @(negedge CLK);
    instr_dec = instr;
    dec_ok = (imem_read === 1'b0) && (exec_en === 1'b0) && (pc === pc0);
    imem_busy = 1'b1;
    imem_rdata = $urandom;
    @(negedge CLK);
    ex_ok = (exec_en === 1'b1) && (imem_read === 1'b0) && (instr === word) && (pc === pc0);
    jump = j; branch = b; zero = z;
    @(negedge CLK);
    ex_ok = ex_ok && (exec_en === 1'b0) && (imem_read === 1'b1);
    pc_after = pc;
    jump = 1'b0; branch = 1'b0; zero = 1'b0;
    imem_busy = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    n_cmp++; if (imem_read !== 1'b1) begin n_bad++; $display("FAIL reset_imem_read: got %b want 1", imem_read); end
    n_cmp++; if (exec_en !== 1'b0) begin n_bad++; $display("FAIL reset_exec_en: got %b want 0", exec_en); end
    n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", instr); end
  endtask

  task automatic test_sequential();
    int fc; logic hd, dk, ek; logic [31:0] idec, pa, w;
    for (int k = 1; k <= 4; k++) begin
      w = 32'h0112_3344 + 32'(k);   // nonzero offset field must be ignored
      run_instr(w, 0, 1'b0, 1'b0, 1'b1, fc, hd, idec, dk, ek, pa);
      $display("seq  #%0d word=%h pc_after=%h", k, w, pa);
      n_cmp++; if (pa !== 32'(4 * k)) begin n_bad++; $display("FAIL seq_pc: got %h want %h", pa, 32'(4 * k)); end
      n_cmp++; if (fc !== 1) begin n_bad++; $display("FAIL seq_fetch_cycles: got %0d want 1", fc); end
      n_cmp++; if (idec !== w) begin n_bad++; $display("FAIL seq_instr: got %h want %h", idec, w); end
      n_cmp++; if (!dk || !ek) begin n_bad++; $display("FAIL seq_decode_exec: got dec=%b exec=%b want 1 1", dk, ek); end
    end
  endtask

  task automatic test_jump();
    int fc; logic hd, dk, ek; logic [31:0] idec, pa;
    run_instr(32'h02FE_0000, 0, 1'b1, 1'b0, 1'b0, fc, hd, idec, dk, ek, pa);
    $display("jump off=FE pc_after=%h", pa);
    n_cmp++; if (pa !== 32'h0000_000C) begin n_bad++; $display("FAIL jump_back: got %h want %h", pa, 32'h0C); end
    n_cmp++; if (!ek) begin n_bad++; $display("FAIL jump_exec_pulse: got %b want 1", ek); end
  endtask

  task automatic test_busy();
    int fc; logic hd, dk, ek; logic [31:0] idec, pa;
    run_instr(32'h0A00_0055, 5, 1'b0, 1'b0, 1'b0, fc, hd, idec, dk, ek, pa);
    $display("busy5 fetch_cycles=%0d pc_after=%h", fc, pa);
    n_cmp++; if (fc !== 6) begin n_bad++; $display("FAIL busy_fetch_cycles: got %0d want 6", fc); end
    n_cmp++; if (hd !== 1'b1) begin n_bad++; $display("FAIL busy_instr_held: got %b want 1", hd); end
    n_cmp++; if (idec !== 32'h0A00_0055) begin n_bad++; $display("FAIL busy_instr: got %h want %h", idec, 32'h0A00_0055); end
    n_cmp++; if (pa !== 32'h10) begin n_bad++; $display("FAIL busy_pc: got %h want %h", pa, 32'h10); end
    for (int k = 1; k <= 4; k++) begin
      run_instr(32'h0100_0000, 0, 1'b0, 1'b0, 1'b0, fc, hd, idec, dk, ek, pa);
      n_cmp++; if (pa !== 32'h10 + 32'(4 * k)) begin n_bad++; $display("FAIL b2b_pc: got %h want %h", pa, 32'h10 + 32'(4 * k)); end
    end
  endtask

  task automatic test_branch();
    int fc; logic hd, dk, ek; logic [31:0] idec, pa;
    // {word, jump, branch, zero, expected pc}; starts at pc = 0x20
    logic [31:0] words [5] = '{32'h0402_0000, 32'h02FC_0000, 32'h0402_0000, 32'h0601_0000, 32'hFF7F_0000};
    logic [2:0]  ctl   [5] = '{3'b011,        3'b100,        3'b010,        3'b110,        3'b001};
    logic [31:0] exp   [5] = '{32'h2C,        32'h20,        32'h24,        32'h2C,        32'h30};
    for (int k = 0; k < 5; k++) begin
      run_instr(words[k], 0, ctl[k][2], ctl[k][1], ctl[k][0], fc, hd, idec, dk, ek, pa);
      $display("br   #%0d word=%h jbz=%b pc_after=%h", k, words[k], ctl[k], pa);
      n_cmp++; if (pa !== exp[k]) begin n_bad++; $display("FAIL branch_pc #%0d: got %h want %h", k, pa, exp[k]); end
    end
  endtask

  task automatic test_wrap();
    int fc; logic hd, dk, ek; logic [31:0] idec, pa;
    do_reset();
    run_instr(32'h02FE_0000, 0, 1'b1, 1'b0, 1'b0, fc, hd, idec, dk, ek, pa);
    $display("wrap jump below zero pc_after=%h", pa);
    n_cmp++; if (pa !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_negative: got %h want %h", pa, 32'hFFFF_FFFC); end
    run_instr(32'h0100_0000, 0, 1'b0, 1'b0, 1'b0, fc, hd, idec, dk, ek, pa);
    $display("wrap step pc_after=%h", pa);
    n_cmp++; if (pa !== 32'h0) begin n_bad++; $display("FAIL wrap_step: got %h want 0", pa); end
  endtask

  task automatic test_reset_exec();
    int fc; logic hd, dk, ek; logic [31:0] idec, pa;
    run_instr(32'h0100_0000, 0, 1'b0, 1'b0, 1'b0, fc, hd, idec, dk, ek, pa);
    imem_busy = 1'b0; imem_rdata = 32'h0305_0000;
    @(negedge CLK);                 // DECODE
    imem_busy = 1'b1;
    @(negedge CLK);                 // EXEC
    n_cmp++; if (exec_en !== 1'b1) begin n_bad++; $display("FAIL rst_exec_reached: got %b want 1", exec_en); end
    RESET = 1'b1; jump = 1'b1;
    @(negedge CLK);
    RESET = 1'b0; jump = 1'b0;
    $display("reset in EXEC pc=%h imem_read=%b exec_en=%b", pc, imem_read, exec_en);
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL rst_exec_pc: got %h want 0", pc); end
    n_cmp++; if (imem_read !== 1'b1 || exec_en !== 1'b0) begin n_bad++; $display("FAIL rst_exec_ctl: got rd=%b en=%b want 1 0", imem_read, exec_en); end
    n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL rst_exec_instr: got %h want 0", instr); end
    @(negedge CLK);
    n_cmp++; if (pc !== 32'h0 || imem_read !== 1'b1) begin n_bad++; $display("FAIL rst_exec_hold: got pc=%h rd=%b want 0 1", pc, imem_read); end
  endtask

  task automatic test_reset_fetch();
    int fc; logic hd, dk, ek; logic [31:0] idec, pa;
    run_instr(32'h0177_0000, 0, 1'b0, 1'b0, 1'b0, fc, hd, idec, dk, ek, pa);
    imem_busy = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    $display("reset in busy FETCH pc=%h instr=%h", pc, instr);
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL rst_fetch_pc: got %h want 0", pc); end
    n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL rst_fetch_instr: got %h want 0", instr); end
    n_cmp++; if (imem_read !== 1'b1 || exec_en !== 1'b0) begin n_bad++; $display("FAIL rst_fetch_ctl: got rd=%b en=%b want 1 0", imem_read, exec_en); end
    run_instr(32'h0100_0000, 0, 1'b0, 1'b0, 1'b0, fc, hd, idec, dk, ek, pa);
    $display("after reset step pc_after=%h", pa);
    n_cmp++; if (pa !== 32'h4) begin n_bad++; $display("FAIL rst_recover_pc: got %h want 4", pa); end
  endtask

  initial begin
    test_reset();
    test_sequential();   // pc 0 -> 0x10
    test_jump();         // 0x10 -> 0x0C
    test_busy();         // 0x0C -> 0x10 -> 0x20
    test_branch();       // 0x20 -> ... -> 0x30
    test_wrap();
    test_reset_exec();
    test_reset_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
